load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter addr_width_p, default 12, the byte-address width of the attached data memory; addresses at or above 2**addr_width_p are out of range.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1, the reset, synchronous and active-high.
REQ-004 SHALL have port req_valid_i, input, 1, pipeline memory request present; held stable while stall_o=1.
REQ-005 SHALL have port req_store_i, input, 1: 1 for store, 0 for load.
REQ-006 SHALL have port req_byte_i, input, 1: 1 for byte access, 0 for word access.
REQ-007 SHALL have port req_signed_i, input, 1: sign-extend byte loads; ignored otherwise.
REQ-008 SHALL have port req_addr_i, input, 32, byte address.
REQ-009 SHALL have port req_wdata_i, input, 32, store data; the low 8 bits are used for byte stores.
REQ-010 SHALL have port stall_o, output, 1, pipeline must hold the request.
REQ-011 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port err_o, output, 1, valid with done_o; the access was rejected.
REQ-013 SHALL have port load_data_o, output, 32, load result, valid with done_o.
REQ-014 SHALL have port mem_port_flat_o, output, $bits(mem_in_s), drives the memory: valid, wen, byte_not_word, write_data, yumi.
REQ-015 SHALL have port mem_addr_o, output, 32, memory address, equal to req_addr_i.
REQ-016 SHALL have port mem_port_flat_i, input, $bits(mem_out_s), memory response: valid, read_data, yumi.
REQ-017 SHALL have port load_count_o, output, 16, completed loads, wrapping.
REQ-018 SHALL have port store_count_o, output, 16, completed stores, wrapping.

Function
REQ-019 SHALL implement the states IDLE, WAIT_RESP and DONE.
REQ-020 IDLE SHALL behave as follows: with req_valid_i=1 and the request legal, drive mem valid=1, wen=req_store_i, byte_not_word=req_byte_i, write_data=req_wdata_i, all combinationally; on mem_out.yumi=1 go to WAIT_RESP, otherwise stay and keep valid asserted.
REQ-021 A request SHALL be illegal if it is a word access with addr[1:0]!=0, or if addr>>addr_width_p!=0; an illegal request SHALL never assert mem valid, SHALL go IDLE->DONE with err_o=1 and load_data_o=0, and SHALL not increment the counters.
REQ-022 Mem valid SHALL be 0 in WAIT_RESP and DONE, so that no second request is issued.
REQ-023 WAIT_RESP SHALL, when mem_out.valid=1, assert mem yumi=1 that cycle, register the formatted read data (loads only) and go to DONE; otherwise it SHALL stay with yumi=0.
REQ-024 Mem yumi SHALL be 1 only in WAIT_RESP with mem_out.valid=1.
REQ-025 Load formatting SHALL be: word returns read_data unchanged; byte returns read_data[7:0], zero- or sign-extended per req_signed_i; a store returns 0.
REQ-026 DONE SHALL assert done_o=1 and stall_o=0 for exactly one cycle, increment load_count_o or store_count_o (mod 2**16) at that edge, and then go to IDLE.
REQ-027 The pipeline SHALL treat the request as consumed in the DONE cycle; req_valid_i in the following IDLE cycle SHALL be a new request.
REQ-028 stall_o SHALL equal req_valid_i in IDLE and 1 in WAIT_RESP.
REQ-029 A legal access against a memory with single-cycle response SHALL take 3 cycles: issue, WAIT_RESP, DONE.
REQ-030 req_valid_i=0 in IDLE SHALL produce no memory activity and stall_o=0.

Reset
REQ-031 While reset=1, state SHALL be IDLE, done_o=0, err_o=0, load_data_o=0, load_count_o=0 and store_count_o=0, and mem valid and yumi SHALL be 0.
REQ-032 Reset in WAIT_RESP or DONE SHALL abandon the access without a done_o pulse or a counter update.

Structure
REQ-033 mem_in_s and mem_out_s SHALL remain in definitions.sv, and the lsu_state_e enum SHALL be added there.
REQ-034 Byte select and extension SHALL be one combinational sub-module, lsu_load_align.

Verification
REQ-035 Word store of 0xDEADBEEF to 0x100, then word load from 0x100 -> each takes 3 cycles; the load has done_o=1 and load_data_o=0xDEADBEEF; store_count_o=1 and load_count_o=1.
REQ-036 Byte store of 0x80 to 0x203, then byte load from 0x203 with req_signed_i=1, then with 0 -> load_data_o=0xFFFFFF80, then 0x00000080.
REQ-037 Word load from 0x102 -> mem valid never asserted; done_o=1 with err_o=1 on the 2nd cycle; load_data_o=0; counters unchanged.
REQ-038 Store to 0x1000 with addr_width_p=12 -> err_o=1 and no memory write; a subsequent load from 0x000 returns the prior contents.
REQ-039 Memory model delays mem_out.valid by 4 cycles -> stall_o stays 1 throughout, yumi pulses only once, and done_o follows one cycle later.
REQ-040 Reset asserted during WAIT_RESP -> no done_o pulse, counters remain 0, and a next load completes normally.

Source files
------------

// File: rtl/definitions.sv
// Shared types for the load/store unit and its data-memory port.
//
// mem_in_s  : request bundle driven towards the data memory
//             (valid, wen, byte_not_word, write_data, yumi).
// mem_out_s : response bundle coming back from the data memory
//             (valid, read_data, yumi).
// lsu_state_e : sequencing states of the load/store unit.
package definitions;

  // Request side: yumi here acknowledges the memory's read response.
  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic [31:0] write_data;
    logic        yumi;
  } mem_in_s;

  // Response side: yumi here means the memory accepted our request.
  typedef struct packed {
    logic        valid;
    logic [31:0] read_data;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESP,
    DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Formats raw memory read data into the value handed back to the pipeline.
//
// Ports:
//   read_data     : raw 32-bit word from the memory response
//   byte_not_word : 1 = byte access, result comes from read_data[7:0]
//   sign_extend   : for byte loads, replicate bit 7 into the upper bits
//   is_store      : stores return zero
//   load_data     : formatted result
module lsu_load_align (
  input  logic [31:0] read_data,
  input  logic        byte_not_word,
  input  logic        sign_extend,
  input  logic        is_store,
  output logic [31:0] load_data
);

  // The memory returns the addressed byte in the low lane, so a byte load
  // only needs extension; the upper lanes of the response are don't-care.
  always_comb begin
    load_data = read_data;
    if (is_store) begin
      load_data = '0;
    end else if (byte_not_word) begin
      load_data = {{24{sign_extend & read_data[7]}}, read_data[7:0]};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline memory request at a time into a
// valid/yumi handshake with the data memory, formats load results and
// counts completed loads and stores.
//
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   req_*_i             : pipeline request (valid, store, byte, signed, addr, wdata)
//   stall_o             : pipeline must hold the current request
//   done_o, err_o       : one-cycle completion pulse and rejection flag
//   load_data_o         : load result, valid with done_o
//   mem_port_flat_o     : packed mem_in_s towards the memory
//   mem_addr_o          : memory byte address (the request address)
//   mem_port_flat_i     : packed mem_out_s from the memory
//   load_count_o        : completed loads, wrapping
//   store_count_o       : completed stores, wrapping
module load_store_unit
  import definitions::*;
#(
  parameter int addr_width_p = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid_i,
  input  logic                        req_store_i,
  input  logic                        req_byte_i,
  input  logic                        req_signed_i,
  input  logic [31:0]                 req_addr_i,
  input  logic [31:0]                 req_wdata_i,
  output logic                        stall_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [31:0]                 load_data_o,
  output logic [$bits(mem_in_s)-1:0]  mem_port_flat_o,
  output logic [31:0]                 mem_addr_o,
  input  logic [$bits(mem_out_s)-1:0] mem_port_flat_i,
  output logic [15:0]                 load_count_o,
  output logic [15:0]                 store_count_o
);

  lsu_state_e  state;
  logic        op_store;
  mem_in_s     mem_in;
  mem_out_s    mem_out;
  logic        addr_aligned;
  logic        addr_in_range;
  logic        req_legal;
  logic        issue;
  logic [31:0] aligned_data;

  assign mem_out         = mem_out_s'(mem_port_flat_i);
  assign mem_port_flat_o = mem_in;
  assign mem_addr_o      = req_addr_i;

  // Word accesses must be word aligned and every access must fall inside
  // the attached memory; anything else is rejected without touching it.
  assign addr_aligned  = req_byte_i || (req_addr_i[1:0] == 2'b00);
  assign addr_in_range = (req_addr_i >> addr_width_p) == 32'd0;
  assign req_legal     = addr_aligned && addr_in_range;
  assign issue         = !reset && (state == IDLE) && req_valid_i && req_legal;

  // Request fields pass straight through; valid and yumi are gated by state
  // and by reset so a reset mid-access never leaks a handshake.
  always_comb begin
    mem_in               = '0;
    mem_in.valid         = issue;
    mem_in.wen           = req_store_i;
    mem_in.byte_not_word = req_byte_i;
    mem_in.write_data    = req_wdata_i;
    mem_in.yumi          = !reset && (state == WAIT_RESP) && mem_out.valid;
  end

  always_comb begin
    stall_o = 1'b0;
    case (state)
      IDLE:      stall_o = req_valid_i;
      WAIT_RESP: stall_o = 1'b1;
      default:   stall_o = 1'b0;
    endcase
  end

  lsu_load_align u_align (
    .read_data     (mem_out.read_data),
    .byte_not_word (req_byte_i),
    .sign_extend   (req_signed_i),
    .is_store      (op_store),
    .load_data     (aligned_data)
  );

  // done_o/err_o/load_data_o are set on entry to DONE so they are plain
  // registers; counters advance on the edge that leaves DONE, and only
  // for accesses that actually reached the memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_store      <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      load_data_o   <= '0;
      load_count_o  <= '0;
      store_count_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          err_o  <= 1'b0;
          if (req_valid_i && !req_legal) begin
            state       <= DONE;
            done_o      <= 1'b1;
            err_o       <= 1'b1;
            load_data_o <= '0;
          end else if (issue && mem_out.yumi) begin
            state    <= WAIT_RESP;
            op_store <= req_store_i;
          end
        end
        WAIT_RESP: begin
          if (mem_out.valid) begin
            state       <= DONE;
            done_o      <= 1'b1;
            err_o       <= 1'b0;
            load_data_o <= aligned_data;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          err_o  <= 1'b0;
          if (!err_o) begin
            if (op_store) begin
              store_count_o <= store_count_o + 16'd1;
            end else begin
              load_count_o <= load_count_o + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: a byte-array memory device with
// programmable response latency, directed vectors from a table, a reset
// mid-access sequence and randomized traffic against a reference model.
module tb_load_store_unit;
  import definitions::*;

  localparam int mem_bytes = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic [31:0] mem_addr;
  logic [15:0] load_count;
  logic [15:0] store_count;
  logic [$bits(mem_in_s)-1:0]  mem_in_flat;
  logic [$bits(mem_out_s)-1:0] mem_out_flat;
  mem_in_s     mem_in;
  mem_out_s    mem_out;

  int checks = 0;
  int errors = 0;
  int mem_latency = 1;
  int exp_loads = 0;
  int exp_stores = 0;

  always #5 clk = ~clk;

  load_store_unit #(.addr_width_p(12)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid_i     (req_valid),
    .req_store_i     (req_store),
    .req_byte_i      (req_byte),
    .req_signed_i    (req_signed),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .stall_o         (stall),
    .done_o          (done),
    .err_o           (err),
    .load_data_o     (load_data),
    .mem_port_flat_o (mem_in_flat),
    .mem_addr_o      (mem_addr),
    .mem_port_flat_i (mem_out_flat),
    .load_count_o    (load_count),
    .store_count_o   (store_count)
  );

  assign mem_in       = mem_in_s'(mem_in_flat);
  assign mem_out_flat = mem_out;

  // Memory device: accepts a request immediately when idle, answers after
  // mem_latency cycles and holds the answer until the unit takes it.
  logic [7:0]  dev_mem [mem_bytes];
  logic        dev_pending;
  int          dev_wait;
  logic [31:0] dev_rdata;
  logic [11:0] dev_a;

  assign dev_a = mem_addr[11:0];

  always_comb begin
    mem_out           = '0;
    mem_out.yumi      = mem_in.valid && !dev_pending;
    mem_out.valid     = dev_pending && (dev_wait == 0);
    mem_out.read_data = mem_out.valid ? dev_rdata : 32'h0;
  end

  always @(posedge clk) begin
    if (reset) begin
      dev_pending <= 1'b0;
      dev_wait    <= 0;
      dev_rdata   <= '0;
      for (int i = 0; i < mem_bytes; i++) dev_mem[i] <= 8'(i) ^ 8'h5A;
    end else if (dev_pending) begin
      if (dev_wait != 0) dev_wait <= dev_wait - 1;
      else if (mem_in.yumi) dev_pending <= 1'b0;
    end else if (mem_in.valid && mem_out.yumi) begin
      dev_pending <= 1'b1;
      dev_wait    <= mem_latency - 1;
      if (mem_in.wen) begin
        dev_rdata <= 32'($urandom);
        if (mem_in.byte_not_word) begin
          dev_mem[dev_a] <= mem_in.write_data[7:0];
        end else begin
          dev_mem[dev_a]        <= mem_in.write_data[7:0];
          dev_mem[dev_a + 12'd1] <= mem_in.write_data[15:8];
          dev_mem[dev_a + 12'd2] <= mem_in.write_data[23:16];
          dev_mem[dev_a + 12'd3] <= mem_in.write_data[31:24];
        end
      end else if (mem_in.byte_not_word) begin
        dev_rdata <= (32'($urandom) & 32'hFFFF_FF00) | {24'h0, dev_mem[dev_a]};
      end else begin
        dev_rdata <= {dev_mem[dev_a + 12'd3], dev_mem[dev_a + 12'd2],
                      dev_mem[dev_a + 12'd1], dev_mem[dev_a]};
      end
    end
  end

  // Reference memory and rules, kept independently of the device above.
  logic [7:0] ref_mem [mem_bytes];

  function automatic logic ref_legal(input logic bt, input logic [31:0] addr);
    return (bt || (addr % 32'd4 == 32'd0)) && (addr < 32'(mem_bytes));
  endfunction

  function automatic logic [31:0] ref_load(input logic bt, input logic sg, input logic [31:0] addr);
    int a;
    int v;
    logic [31:0] w;
    a = int'(addr);
    if (!bt) begin
      w = 0;
      for (int i = 3; i >= 0; i--) w = w * 256 + 32'(ref_mem[a + i]);
      return w;
    end
    v = int'(ref_mem[a]);
    if (sg && v >= 128) v = v - 256;
    return 32'(v);
  endfunction

  task automatic ref_store(input logic bt, input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 0; i < (bt ? 1 : 4); i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
  endtask

  typedef struct {
    logic        got;
    logic        err;
    logic [31:0] data;
    int          cycles;
    int          valid_cycles;
    int          yumi_cycles;
    logic        stall_ok;
    logic        done_stall;
    logic        addr_ok;
  } obs_t;

  typedef struct {
    logic        store;
    logic        byte_acc;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          latency;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one request from a posedge+1 slot until done_o is seen (bounded),
  // recording what the unit did along the way; returns at posedge+1.
  task automatic apply_stimulus(input logic st, input logic bt, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int lat, output obs_t o);
    o = '{default: '0};
    o.stall_ok = 1'b1;
    o.addr_ok  = 1'b1;
    mem_latency = lat;
    req_store = st; req_byte = bt; req_signed = sg;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    while (!o.got && o.cycles < 40) begin
      #1;
      o.cycles++;
      if (mem_in.valid) o.valid_cycles++;
      if (mem_in.valid && mem_addr !== addr) o.addr_ok = 1'b0;
      if (mem_in.yumi) o.yumi_cycles++;
      if (done) begin
        o.got = 1'b1; o.err = err; o.data = load_data; o.done_stall = stall;
      end else if (!stall) begin
        o.stall_ok = 1'b0;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      req_store = 1'($urandom_range(0, 1));
      req_byte  = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      #1;
      check_output("idle_stall", 32'(stall), 32'd0);
      check_output("idle_mem_valid", 32'(mem_in.valid), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // Holds reset for two cycles with a legal request pending, then releases.
  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b1; req_store = 1'b0; req_byte = 1'b0;
    req_addr = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_load_data", load_data, 32'd0);
    check_output("rst_load_count", 32'(load_count), 32'd0);
    check_output("rst_store_count", 32'(store_count), 32'd0);
    check_output("rst_mem_valid", 32'(mem_in.valid), 32'd0);
    check_output("rst_mem_yumi", 32'(mem_in.yumi), 32'd0);
    reset = 1'b0; req_valid = 1'b0;
    exp_loads = 0; exp_stores = 0;
  endtask

  task automatic check_access(input string tag, input obs_t o, input logic exp_err,
                              input logic [31:0] exp_data, input int exp_cycles);
    check_output({tag, "_done"}, 32'(o.got), 32'd1);
    check_output({tag, "_err"}, 32'(o.err), 32'(exp_err));
    check_output({tag, "_data"}, o.data, exp_data);
    check_output({tag, "_cycles"}, 32'(o.cycles), 32'(exp_cycles));
    check_output({tag, "_valid_cycles"}, 32'(o.valid_cycles), exp_err ? 32'd0 : 32'd1);
    check_output({tag, "_yumi_cycles"}, 32'(o.yumi_cycles), exp_err ? 32'd0 : 32'd1);
    check_output({tag, "_stall_held"}, 32'(o.stall_ok), 32'd1);
    check_output({tag, "_done_stall"}, 32'(o.done_stall), 32'd0);
    check_output({tag, "_mem_addr"}, 32'(o.addr_ok), 32'd1);
    check_output({tag, "_load_count"}, 32'(load_count), 32'(16'(exp_loads)));
    check_output({tag, "_store_count"}, 32'(store_count), 32'(16'(exp_stores)));
  endtask

  function automatic void add_vec(input logic st, input logic bt, input logic sg,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input int lat, input logic e_err,
                                  input logic [31:0] e_data, input int e_cyc);
    vec_t v;
    v = '{st, bt, sg, addr, wdata, lat, e_err, e_data, e_cyc};
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    obs_t o;
    int done_pulses;

    for (int i = 0; i < mem_bytes; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

    // Memory image after reset is byte[i] = i ^ 0x5A (little-endian words).
    //        st    byte  sign  addr           wdata          lat err  data            cyc
    add_vec(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1, 1'b0, 32'h0000_0000, 3);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         1, 1'b0, 32'hDEAD_BEEF, 3);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         4, 1'b0, 32'hDEAD_BEEF, 6);
    add_vec(1'b1, 1'b1, 1'b0, 32'h0000_0203, 32'h1234_5680, 1, 1'b0, 32'h0000_0000, 3);
    add_vec(1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'h0,         1, 1'b0, 32'hFFFF_FF80, 3);
    add_vec(1'b0, 1'b1, 1'b0, 32'h0000_0203, 32'h0,         1, 1'b0, 32'h0000_0080, 3);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0,         2, 1'b0, 32'h8058_5B5A, 4);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0000_0102, 32'h0,         1, 1'b1, 32'h0000_0000, 2);
    add_vec(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'hCAFE_F00D, 1, 1'b1, 32'h0000_0000, 2);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         1, 1'b0, 32'h5958_5B5A, 3);
    add_vec(1'b0, 1'b1, 1'b1, 32'h0000_01FF, 32'h0,         1, 1'b0, 32'hFFFF_FFA5, 3);
    add_vec(1'b0, 1'b0, 1'b1, 32'h0000_0FFC, 32'h0,         1, 1'b0, 32'hA5A4_A7A6, 3);
    add_vec(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0,         1, 1'b1, 32'h0000_0000, 2);
    add_vec(1'b1, 1'b1, 1'b0, 32'h0000_0FFF, 32'h0000_007F, 3, 1'b0, 32'h0000_0000, 5);
    add_vec(1'b0, 1'b1, 1'b1, 32'h0000_0FFF, 32'h0,         1, 1'b0, 32'h0000_007F, 3);
    add_vec(1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0,         1, 1'b1, 32'h0000_0000, 2);

    do_reset();
    idle_cycles(2);

    // Reset while the memory is still working on a load.
    mem_latency = 8;
    req_store = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 32'h100; req_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_output("wait_resp_stall", 32'(stall), 32'd1);
    reset = 1'b1; req_valid = 1'b0;
    #1;
    check_output("mid_reset_yumi", 32'(mem_in.yumi), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    done_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (done) done_pulses++;
      @(posedge clk); #1;
    end
    check_output("abandon_done_pulses", 32'(done_pulses), 32'd0);
    check_output("abandon_load_count", 32'(load_count), 32'd0);
    check_output("abandon_store_count", 32'(store_count), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, 1, o);
    exp_loads = 1;
    check_access("after_abandon", o, 1'b0, 32'h5D5C_5F5E, 3);

    do_reset();
    idle_cycles(1);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].store, vecs[i].byte_acc, vecs[i].sign, vecs[i].addr,
                     vecs[i].wdata, vecs[i].latency, o);
      if (!vecs[i].exp_err) begin
        if (vecs[i].store) begin
          exp_stores++;
          ref_store(vecs[i].byte_acc, vecs[i].addr, vecs[i].wdata);
        end else begin
          exp_loads++;
        end
      end
      check_access($sformatf("vec%0d", i), o, vecs[i].exp_err, vecs[i].exp_data,
                   vecs[i].exp_cycles);
      idle_cycles(1);
    end

    // Randomized traffic checked against the reference rules and memory.
    for (int n = 0; n < 150; n++) begin
      logic        st;
      logic        bt;
      logic        sg;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        legal;
      logic [31:0] exp_data;
      int          lat;
      int          r;
      st    = 1'($urandom_range(0, 1));
      bt    = 1'($urandom_range(0, 1));
      sg    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      lat   = $urandom_range(1, 3);
      r     = $urandom_range(0, 9);
      if (r == 0) addr = $urandom;
      else if (r < 6) addr = 32'($urandom_range(0, 63));
      else addr = 32'($urandom_range(0, mem_bytes - 1));
      if (!bt && r > 2) addr = addr & ~32'd3;
      legal = ref_legal(bt, addr);
      exp_data = 32'd0;
      if (legal) begin
        if (st) begin
          exp_stores++;
          ref_store(bt, addr, wdata);
        end else begin
          exp_loads++;
          exp_data = ref_load(bt, sg, addr);
        end
      end
      apply_stimulus(st, bt, sg, addr, wdata, lat, o);
      check_output("rand_done", 32'(o.got), 32'd1);
      check_output("rand_err", 32'(o.err), 32'(!legal));
      check_output("rand_data", o.data, exp_data);
      check_output("rand_cycles", 32'(o.cycles), legal ? 32'(2 + lat) : 32'd2);
      check_output("rand_load_count", 32'(load_count), 32'(16'(exp_loads)));
      check_output("rand_store_count", 32'(store_count), 32'(16'(exp_stores)));
      idle_cycles($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
